// File: rtl/dmi_fcs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmi_fcs_ctrl
// Description : Frame sequencer that forwards payload words through an external
//               CRC engine and appends the 32-bit FCS as two trailing words.
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_fcs_ctrl #(
    parameter int CRC_LAT   = 2,
    parameter int MAX_WORDS = 760
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sof,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    input  logic        i_eof,
    output logic        o_ready,
    output logic        o_crc_reset,
    output logic        o_crc_enable,
    output logic [15:0] o_crc_data,
    input  logic [31:0] i_crc,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_eof,
    output logic        o_busy,
    output logic        o_err
);

    localparam int            CW          = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] c_MAX_WORDS = CW'(MAX_WORDS);
    localparam logic [CW-1:0] c_ONE       = CW'(1);
    localparam logic [3:0]    c_LAT_LAST  = 4'(CRC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_DATA  = 3'd2,
        S_WAIT  = 3'd3,
        S_FCS_H = 3'd4,
        S_FCS_L = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_count;
    logic [3:0]    r_wait;
    logic          r_pay_valid;
    logic [15:0]   r_pay_data;
    logic          r_err;
    logic          w_accept;
    logic          w_last;
    logic          w_overlen;

    assign w_accept  = (r_state == S_DATA) && i_valid;
    assign w_last    = w_accept && i_eof;
    // A word with i_eof at the limit is a legal end of frame, so only non-final words abort.
    assign w_overlen = w_accept && !i_eof && ((r_count + c_ONE) == c_MAX_WORDS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_crc_reset  = 1'b0;
        o_crc_enable = w_accept;
        o_crc_data   = w_accept ? i_data : 16'h0000;
        o_valid      = r_pay_valid;
        o_data       = r_pay_data;
        o_eof        = 1'b0;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_sof) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                o_crc_reset  = 1'b1;
                w_state_next = S_DATA;
            end
            S_DATA: begin
                o_ready = 1'b1;
                if (w_last) begin
                    w_state_next = S_WAIT;
                end else if (w_overlen) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_wait == c_LAT_LAST) begin
                    w_state_next = S_FCS_H;
                end
            end
            S_FCS_H: begin
                o_valid      = 1'b1;
                o_data       = i_crc[31:16];
                w_state_next = S_FCS_L;
            end
            S_FCS_L: begin
                o_valid      = 1'b1;
                o_data       = i_crc[15:0];
                o_eof        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_err = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_wait      <= 4'd0;
            r_pay_valid <= 1'b0;
            r_pay_data  <= 16'h0000;
            r_err       <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_count <= '0;
            end else if (w_accept && (r_count != c_MAX_WORDS)) begin
                r_count <= r_count + c_ONE;
            end
            r_wait      <= (r_state == S_WAIT) ? (r_wait + 4'd1) : 4'd0;
            r_pay_valid <= w_accept;
            r_pay_data  <= w_accept ? i_data : 16'h0000;
            r_err       <= w_overlen;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmi_fcs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmi_fcs_ctrl
// Description : Scoreboard bench for dmi_fcs_ctrl (CRC_LAT=2, MAX_WORDS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmi_fcs_ctrl;

    localparam int CRC_LAT   = 2;
    localparam int MAX_WORDS = 4;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_sof   = 1'b0;
    logic [15:0] i_data  = 16'h0000;
    logic        i_valid = 1'b0;
    logic        i_eof   = 1'b0;
    logic [31:0] i_crc   = 32'h0;
    logic        o_ready;
    logic        o_crc_reset;
    logic        o_crc_enable;
    logic [15:0] o_crc_data;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_eof;
    logic        o_busy;
    logic        o_err;

    int          vectors     = 0;
    int          miscompares = 0;
    int          n_crc_reset = 0;
    int          n_err       = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_exp;

    dmi_fcs_ctrl #(
        .CRC_LAT   (CRC_LAT),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sof        (i_sof),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_eof        (i_eof),
        .o_ready      (o_ready),
        .o_crc_reset  (o_crc_reset),
        .o_crc_enable (o_crc_enable),
        .o_crc_data   (o_crc_data),
        .i_crc        (i_crc),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_eof        (o_eof),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Output monitor: every valid word must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (o_crc_reset === 1'b1) n_crc_reset++;
        if (o_err === 1'b1) n_err++;
        if (o_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_word: got data=%h eof=%b, required no word", o_data, o_eof);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({o_eof, o_data} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL out_word: got data=%h eof=%b, required data=%h eof=%b",
                             o_data, o_eof, mon_exp[15:0], mon_exp[16]);
                end
            end
        end
    end

    task automatic tick(input logic sof, input logic valid, input logic eof, input logic [15:0] data);
        @(posedge i_clk);
        #1;
        i_sof   = sof;
        i_valid = valid;
        i_eof   = eof;
        i_data  = data;
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic start_frame();
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        idle();
        vectors++;
        if ({o_crc_reset, o_crc_enable, o_ready, o_busy} !== 4'b1001) begin
            miscompares++;
            $display("FAIL init: crc_reset/enable/ready/busy=%b, required 1001",
                     {o_crc_reset, o_crc_enable, o_ready, o_busy});
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic eof, input logic sof);
        tick(sof, 1'b1, eof, d);
        vectors++;
        if ({o_ready, o_crc_enable, o_crc_data} !== {2'b11, d}) begin
            miscompares++;
            $display("FAIL accept: ready/enable/crc_data=%b/%b/%h, required 1/1/%h",
                     o_ready, o_crc_enable, o_crc_data, d);
        end
        exp_q.push_back({1'b0, d});
        if (eof) begin
            exp_q.push_back({1'b0, i_crc[31:16]});
            exp_q.push_back({1'b1, i_crc[15:0]});
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        do begin
            idle();
            k++;
        end while ((exp_q.size() != 0 || o_busy !== 1'b0) && k < budget);
        vectors++;
        if (exp_q.size() != 0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: %0d words outstanding, busy=%b after %0d cycles, required 0 and 0",
                     exp_q.size(), o_busy, k);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_data  = 16'hA5A5;
        i_valid = 1'b1;
        i_crc   = 32'hFFFF_FFFF;
        #12;
        vectors++;
        if ({o_ready, o_crc_reset, o_crc_enable, o_crc_data, o_data, o_valid, o_eof, o_busy, o_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b crc_reset=%b en=%b crc_data=%h data=%h valid=%b eof=%b busy=%b err=%b, required all 0",
                     o_ready, o_crc_reset, o_crc_enable, o_crc_data, o_data, o_valid, o_eof, o_busy, o_err);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        i_data  = 16'h0000;
        idle();
        vectors++;
        if ({o_busy, o_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: busy/ready=%b, required 00", {o_busy, o_ready});
        end
    endtask

    task automatic test_basic();
        int c0;
        i_crc = 32'hDEAD_BEEF;
        c0 = n_crc_reset;
        start_frame();
        send_word(16'h1234, 1'b0, 1'b0);
        send_word(16'h5678, 1'b0, 1'b0);
        send_word(16'h9ABC, 1'b1, 1'b0);
        drain(20);
        vectors++;
        if (n_crc_reset - c0 != 1) begin
            miscompares++;
            $display("FAIL basic_crc_reset: %0d crc_reset cycles, required 1", n_crc_reset - c0);
        end
    endtask

    task automatic test_single();
        logic [2:0] tbl [5];
        tbl = '{3'b110, 3'b100, 3'b110, 3'b111, 3'b000};
        i_crc = 32'hCAFE_F00D;
        start_frame();
        send_word(16'h00FF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            vectors++;
            if ({o_busy, o_valid, o_eof} !== tbl[i]) begin
                miscompares++;
                $display("FAIL single_timing[%0d]: busy/valid/eof=%b, required %b",
                         i, {o_busy, o_valid, o_eof}, tbl[i]);
            end
        end
        drain(4);
    endtask

    task automatic test_overlen();
        int e0;
        i_crc = 32'h1234_5678;
        e0 = n_err;
        start_frame();
        send_word(16'h1111, 1'b0, 1'b0);
        send_word(16'h2222, 1'b0, 1'b0);
        send_word(16'h3333, 1'b0, 1'b0);
        send_word(16'h4444, 1'b0, 1'b0);
        idle();
        vectors++;
        if ({o_err, o_busy, o_valid} !== 3'b101) begin
            miscompares++;
            $display("FAIL overlen_abort: err/busy/valid=%b, required 101", {o_err, o_busy, o_valid});
        end
        idle();
        vectors++;
        if ({o_err, o_busy, o_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL overlen_after: err/busy/valid=%b, required 000", {o_err, o_busy, o_valid});
        end
        for (int i = 0; i < 6; i++) idle();
        start_frame();
        send_word(16'h5555, 1'b0, 1'b0);
        send_word(16'h6666, 1'b0, 1'b0);
        send_word(16'h7777, 1'b0, 1'b0);
        send_word(16'h8888, 1'b1, 1'b0);
        drain(20);
        vectors++;
        if (n_err - e0 != 1) begin
            miscompares++;
            $display("FAIL overlen_err_count: %0d err pulses, required 1", n_err - e0);
        end
    endtask

    task automatic test_gaps();
        i_crc = 32'h0BAD_F00D;
        start_frame();
        send_word(16'hAAAA, 1'b0, 1'b0);
        idle();
        vectors++;
        if ({o_crc_enable, o_ready, o_valid} !== 3'b011) begin
            miscompares++;
            $display("FAIL gap1: enable/ready/valid=%b, required 011", {o_crc_enable, o_ready, o_valid});
        end
        idle();
        vectors++;
        if ({o_crc_enable, o_ready, o_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL gap2: enable/ready/valid=%b, required 010", {o_crc_enable, o_ready, o_valid});
        end
        send_word(16'hBBBB, 1'b1, 1'b0);
        drain(20);
    endtask

    task automatic test_sof_and_reset();
        i_crc = 32'hFEED_FACE;
        start_frame();
        send_word(16'hC0DE, 1'b0, 1'b1);
        idle();
        vectors++;
        if ({o_crc_reset, o_ready, o_busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL sof_in_data: crc_reset/ready/busy=%b, required 011", {o_crc_reset, o_ready, o_busy});
        end
        send_word(16'hD00D, 1'b1, 1'b0);
        idle();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_ready, o_crc_reset, o_crc_enable, o_crc_data, o_data, o_valid, o_eof, o_busy, o_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_in_wait: data=%h valid=%b eof=%b busy=%b err=%b crc_data=%h, required all 0",
                     o_data, o_valid, o_eof, o_busy, o_err, o_crc_data);
        end
        exp_q.delete();
        idle();
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle();
        vectors++;
        if ({o_busy, o_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset: busy/valid=%b, required 00", {o_busy, o_valid});
        end
        start_frame();
        send_word(16'h0042, 1'b1, 1'b0);
        drain(20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_overlen();
        test_gaps();
        test_sof_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmi_fcs_ctrl.md
DMI_FCS_CTRL -- requirements
Module: dmi_fcs_ctrl

Interface
REQ-001 SHALL have parameter CRC_LAT, default 2: cycles from the last o_crc_enable high to a stable, finalized i_crc; legal range 1..15.
REQ-002 SHALL have parameter MAX_WORDS, default 760: maximum payload words per frame, FCS excluded.
REQ-003 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_sof  in  1  frame start request, one-cycle pulse.
REQ-006 SHALL have port i_data  in  16  payload word.
REQ-007 SHALL have port i_valid  in  1  i_data valid.
REQ-008 SHALL have port i_eof  in  1  qualifies the last payload word; meaningful only with i_valid.
REQ-009 SHALL have port o_ready  out  1  word accepted when i_valid & o_ready.
REQ-010 SHALL have port o_crc_reset  out  1  CRC engine preset to all-ones.
REQ-011 SHALL have port o_crc_enable  out  1  CRC engine update strobe.
REQ-012 SHALL have port o_crc_data  out  16  CRC engine data word.
REQ-013 SHALL have port i_crc  in  32  finalized CRC from the engine.
REQ-014 SHALL have port o_data  out  16  output frame word, payload then FCS.
REQ-015 SHALL have port o_valid  out  1  o_data valid.
REQ-016 SHALL have port o_eof  out  1  marks the final FCS word.
REQ-017 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port o_err  out  1  one-cycle over-length abort pulse.

Function
REQ-019 SHALL implement states IDLE, INIT, DATA, WAIT, FCS_H, FCS_L.
REQ-020 SHALL go IDLE->INIT on i_sof; i_sof in any other state is ignored.
REQ-021 SHALL in INIT assert o_crc_reset for exactly one cycle, clear the word counter, and go to DATA.
REQ-022 SHALL assert o_ready only in DATA, and combinationally.
REQ-023 SHALL on each accepted word, in the same cycle, assert o_crc_enable and drive o_crc_data=i_data; the next cycle it SHALL assert o_valid with o_data=that word (1-cycle latency).
REQ-024 SHALL hold o_crc_enable=0 and o_valid=0 on DATA cycles without an accepted word; gaps are allowed.
REQ-025 SHALL go DATA->WAIT on an accepted word with i_eof=1, including when it is the first word.
REQ-026 SHALL in WAIT count CRC_LAT cycles with o_crc_enable=0, then go to FCS_H.
REQ-027 SHALL in FCS_H output o_valid=1 and o_data=i_crc[31:16].
REQ-028 SHALL in FCS_L output o_valid=1, o_data=i_crc[15:0] and o_eof=1, then return to IDLE.
REQ-029 SHALL, when an accepted word without i_eof makes the count equal MAX_WORDS, pulse o_err on the next cycle, skip FCS, and return to IDLE; that word is still forwarded.
REQ-030 SHALL treat an accepted word with i_eof=1 at count MAX_WORDS as a normal end of frame, with no error.
REQ-031 SHALL use a word counter of clog2(MAX_WORDS+1) bits that never wraps.
REQ-032 SHALL hold o_crc_reset, o_crc_enable, o_eof and o_err at 0 outside their defined cycles.

Reset
REQ-033 SHALL on i_rst_n low, immediately and in any state, set state=IDLE, counters=0, and every output 0, including o_data and o_crc_data.
REQ-034 SHALL on reset mid-frame emit no further words and no FCS; the next frame requires a new i_sof.

Verification
REQ-035 SHALL check: i_sof, then 3 words 0x1234, 0x5678, 0x9ABC (last with i_eof), i_crc=0xDEADBEEF -> o_data sequence 1234, 5678, 9ABC, DEAD, BEEF; o_eof on BEEF; exactly one o_crc_reset before the first enable.
REQ-036 SHALL check: single word 0x00FF with i_sof/i_eof and CRC_LAT=2 -> exactly 2 WAIT cycles, then FCS_H and FCS_L; total 5 cycles after acceptance to IDLE.
REQ-037 SHALL check: MAX_WORDS=4 with 4 words and no i_eof -> 4 words out, o_err pulse, no FCS, o_busy low; repeat with i_eof on word 4 -> FCS emitted, o_err stays 0.
REQ-038 SHALL check: i_valid toggling 1,0,0,1 in DATA -> o_crc_enable and o_valid follow each accept, stay 0 on gaps, and the data order is preserved.
REQ-039 SHALL check: i_sof during DATA -> ignored; i_rst_n asserted in WAIT -> all outputs 0 at once, no FCS, and a fresh i_sof runs a normal frame.
